// File: rtl/fifo_port_arbiter.sv
// Round-robin sharing of one FIFO write port among NREQ producers, plus a single-consumer read sequencer.
// Optional: define FIFO_ARB_TAG_EN to prepend the requester index to every written sample.
module fifo_port_arbiter #(
    parameter int NREQ   = 4,
    parameter int DBITS  = 8,
    parameter int GAP    = 1,
    parameter int RD_LAT = 2,
`ifdef FIFO_ARB_TAG_EN
    localparam int IDW   = $clog2(NREQ),
    localparam int OW    = DBITS + IDW
`else
    localparam int OW    = DBITS
`endif
) (
    input  logic                  SYS_CLK,
    input  logic                  reset,
    input  logic [NREQ-1:0]       req,
    input  logic [NREQ*DBITS-1:0] req_data,
    output logic [NREQ-1:0]       gnt,
    output logic                  fifo_wr,
    output logic [OW-1:0]         fifo_din,
    input  logic                  fifo_full,
    input  logic                  fifo_empty,
    input  logic                  rd_req,
    output logic                  fifo_rd,
    input  logic [OW-1:0]         fifo_dout,
    output logic [OW-1:0]         rd_data,
    output logic                  rd_valid,
    output logic                  rd_busy
);

    localparam int PW = $clog2(NREQ);

    typedef enum logic [1:0] {
        W_IDLE = 2'd0,
        W_STRB = 2'd1,
        W_GAP  = 2'd2
    } wr_state_t;

    typedef enum logic [1:0] {
        R_IDLE = 2'd0,
        R_STRB = 2'd1,
        R_WAIT = 2'd2,
        R_DONE = 2'd3
    } rd_state_t;

    wr_state_t         wr_state_r;
    rd_state_t         rd_state_r;
    logic [PW-1:0]     ptr_r;
    logic [PW-1:0]     win_r;
    logic [3:0]        gap_cnt_r;
    logic [2:0]        lat_cnt_r;
    logic [PW-1:0]     pick_s;
    logic [DBITS-1:0]  sel_data_s;
    logic [OW-1:0]     din_s;

    // First requester at or above the pointer, wrapping past NREQ-1 back to 0.
    function automatic logic [PW-1:0] rr_pick(input logic [NREQ-1:0] r, input logic [PW-1:0] p);
        logic [PW:0]   idx;
        logic [PW-1:0] sel;
        sel = '0;
        for (int k = NREQ - 1; k >= 0; k--) begin
            idx = {1'b0, p} + (PW+1)'(k);
            if (idx >= (PW+1)'(NREQ)) begin
                idx = idx - (PW+1)'(NREQ);
            end
            if (r[idx[PW-1:0]]) begin
                sel = idx[PW-1:0];
            end
        end
        return sel;
    endfunction

    // Winner selection and the data word it would write.
    always_comb begin
        pick_s     = rr_pick(req, ptr_r);
        sel_data_s = req_data[pick_s*DBITS +: DBITS];
`ifdef FIFO_ARB_TAG_EN
        din_s      = {pick_s, sel_data_s};
`else
        din_s      = sel_data_s;
`endif
    end

    // Write sequencer: latch a winner, strobe it for one cycle, then hold off GAP cycles.
    always_ff @(posedge SYS_CLK or negedge reset) begin
        if (!reset) begin
            wr_state_r <= W_IDLE;
            ptr_r      <= '0;
            win_r      <= '0;
            gap_cnt_r  <= 4'd0;
            gnt        <= '0;
            fifo_wr    <= 1'b0;
            fifo_din   <= '0;
        end else begin
            case (wr_state_r)
                W_IDLE: begin
                    gnt     <= '0;
                    fifo_wr <= 1'b0;
                    if ((|req) && !fifo_full) begin
                        win_r      <= pick_s;
                        fifo_din   <= din_s;
                        wr_state_r <= W_STRB;
                    end
                end
                W_STRB: begin
                    gnt     <= NREQ'(1) << win_r;
                    fifo_wr <= 1'b1;
                    if (win_r == PW'(NREQ - 1)) begin
                        ptr_r <= '0;
                    end else begin
                        ptr_r <= win_r + PW'(1);
                    end
                    if (GAP == 0) begin
                        wr_state_r <= W_IDLE;
                    end else begin
                        gap_cnt_r  <= 4'(GAP - 1);
                        wr_state_r <= W_GAP;
                    end
                end
                W_GAP: begin
                    gnt     <= '0;
                    fifo_wr <= 1'b0;
                    if (gap_cnt_r == 4'd0) begin
                        wr_state_r <= W_IDLE;
                    end else begin
                        gap_cnt_r <= gap_cnt_r - 4'd1;
                    end
                end
                default: begin
                    gnt        <= '0;
                    fifo_wr    <= 1'b0;
                    wr_state_r <= W_IDLE;
                end
            endcase
        end
    end

    // Read sequencer: strobe, wait RD_LAT, capture, then pulse rd_valid; busy clears one cycle later.
    always_ff @(posedge SYS_CLK or negedge reset) begin
        if (!reset) begin
            rd_state_r <= R_IDLE;
            lat_cnt_r  <= 3'd0;
            fifo_rd    <= 1'b0;
            rd_data    <= '0;
            rd_valid   <= 1'b0;
            rd_busy    <= 1'b0;
        end else begin
            case (rd_state_r)
                R_IDLE: begin
                    rd_valid <= 1'b0;
                    if (rd_req && !fifo_empty && !rd_busy) begin
                        fifo_rd    <= 1'b1;
                        rd_busy    <= 1'b1;
                        rd_state_r <= R_STRB;
                    end else begin
                        fifo_rd <= 1'b0;
                        rd_busy <= 1'b0;
                    end
                end
                R_STRB: begin
                    fifo_rd    <= 1'b0;
                    lat_cnt_r  <= 3'(RD_LAT - 1);
                    rd_state_r <= R_WAIT;
                end
                R_WAIT: begin
                    if (lat_cnt_r == 3'd0) begin
                        rd_data    <= fifo_dout;
                        rd_state_r <= R_DONE;
                    end else begin
                        lat_cnt_r <= lat_cnt_r - 3'd1;
                    end
                end
                R_DONE: begin
                    rd_valid   <= 1'b1;
                    rd_state_r <= R_IDLE;
                end
                default: begin
                    fifo_rd    <= 1'b0;
                    rd_valid   <= 1'b0;
                    rd_busy    <= 1'b0;
                    rd_state_r <= R_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fifo_port_arbiter.sv
// Self-checking bench for fifo_port_arbiter: directed vectors and sequences, then random traffic vs a timing model.
module tb_fifo_port_arbiter;

    localparam int NREQ   = 4;
    localparam int DBITS  = 8;
    localparam int GAP    = 1;
    localparam int RD_LAT = 2;
    localparam int IDW    = 2;
`ifdef FIFO_ARB_TAG_EN
    localparam int OW     = DBITS + IDW;
`else
    localparam int OW     = DBITS;
`endif
    localparam int NCYC   = 800;
    localparam int NARR   = NCYC + 24;

    logic                  SYS_CLK = 1'b0;
    logic                  reset;
    logic [NREQ-1:0]       req;
    logic [NREQ*DBITS-1:0] req_data;
    logic [NREQ-1:0]       gnt;
    logic                  fifo_wr;
    logic [OW-1:0]         fifo_din;
    logic                  fifo_full;
    logic                  fifo_empty;
    logic                  rd_req;
    logic                  fifo_rd;
    logic [OW-1:0]         fifo_dout;
    logic [OW-1:0]         rd_data;
    logic                  rd_valid;
    logic                  rd_busy;

    int n_cmp = 0;
    int n_bad = 0;

    typedef struct packed {
        logic [NREQ-1:0] req;
        logic [NREQ-1:0] gnt;
    } arb_vec_t;

    arb_vec_t        tbl [0:7];
    logic [NREQ-1:0] exp_gnt   [0:NARR-1];
    logic [OW-1:0]   exp_din   [0:NARR-1];
    logic            exp_rd    [0:NARR-1];
    logic            exp_valid [0:NARR-1];
    logic            exp_busy  [0:NARR-1];
    int              exp_src   [0:NARR-1];
    logic [OW-1:0]   dout_hist [0:NARR-1];
    logic [DBITS-1:0] rdat     [0:NREQ-1];

    fifo_port_arbiter #(
        .NREQ(NREQ), .DBITS(DBITS), .GAP(GAP), .RD_LAT(RD_LAT)
    ) dut (
        .SYS_CLK(SYS_CLK), .reset(reset), .req(req), .req_data(req_data),
        .gnt(gnt), .fifo_wr(fifo_wr), .fifo_din(fifo_din),
        .fifo_full(fifo_full), .fifo_empty(fifo_empty), .rd_req(rd_req),
        .fifo_rd(fifo_rd), .fifo_dout(fifo_dout), .rd_data(rd_data),
        .rd_valid(rd_valid), .rd_busy(rd_busy)
    );

    always #5 SYS_CLK = ~SYS_CLK;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic tick;
        @(posedge SYS_CLK);
        #1;
    endtask

    task automatic to_neg;
        @(negedge SYS_CLK);
    endtask

    // Expected write word: source index in the MSBs only when tagging is built in.
    function automatic logic [OW-1:0] mk_din(input int idx, input logic [DBITS-1:0] d);
        logic [IDW+DBITS-1:0] full_v;
        full_v = {IDW'(idx), d};
        return full_v[OW-1:0];
    endfunction

    initial begin
        #200000;
        $display("FAIL watchdog: time limit reached, expected $finish earlier");
        $fatal(1);
    end

    initial begin
        int wfree;
        int rfree;
        int ptr;
        int w;
        logic [NREQ-1:0] rq;

        tbl[0] = '{4'b0001, 4'b0001};
        tbl[1] = '{4'b0101, 4'b0100};
        tbl[2] = '{4'b0011, 4'b0001};
        tbl[3] = '{4'b1001, 4'b1000};
        tbl[4] = '{4'b1010, 4'b0010};
        tbl[5] = '{4'b0011, 4'b0001};
        tbl[6] = '{4'b1100, 4'b0100};
        tbl[7] = '{4'b1111, 4'b1000};

        // Reset held with all requesters active
        reset      = 1'b0;
        req        = 4'hF;
        req_data   = {8'h44, 8'h33, 8'h22, 8'h11};
        fifo_full  = 1'b0;
        fifo_empty = 1'b0;
        rd_req     = 1'b0;
        fifo_dout  = '0;
        repeat (3) @(posedge SYS_CLK);
        to_neg;
        check("rst_gnt", gnt, 64'd0);
        check("rst_fifo_wr", fifo_wr, 64'd0);
        check("rst_fifo_din", fifo_din, 64'd0);
        check("rst_fifo_rd", fifo_rd, 64'd0);
        check("rst_rd_data", rd_data, 64'd0);
        check("rst_rd_valid", rd_valid, 64'd0);
        check("rst_rd_busy", rd_busy, 64'd0);

        // Fairness: grants rotate 0..3 every 2+GAP cycles starting 2 cycles after release
        tick;
        reset = 1'b1;
        for (int c = 0; c < 15; c++) begin
            logic [NREQ-1:0] eg;
            int slot;
            eg   = '0;
            slot = ((c - 2) / 3) % NREQ;
            if (c >= 2 && (c - 2) % 3 == 0) eg = NREQ'(1) << slot;
            to_neg;
            check("rr_gnt", {gnt, fifo_wr}, {eg, |eg});
            if (eg != '0) check("rr_din", fifo_din, mk_din(slot, req_data[slot*DBITS +: DBITS]));
            if (c < 14) tick;
        end
        // Asynchronous reset in the middle of a strobe cycle
        reset = 1'b0;
        #1;
        check("rst_abort", {gnt, fifo_wr}, 64'd0);

        // Table of request patterns against a freshly reset pointer
        req = '0;
        tick;
        reset = 1'b1;
        for (int e = 0; e < 8; e++) begin
            req      = tbl[e].req;
            req_data = 32'($urandom);
            w = 0;
            for (int b = 0; b < NREQ; b++) if (tbl[e].gnt[b]) w = b;
            to_neg;
            check("tbl_lat0", {gnt, fifo_wr}, 64'd0);
            tick;
            to_neg;
            check("tbl_lat1", {gnt, fifo_wr}, 64'd0);
            tick;
            to_neg;
            check("tbl_gnt", {gnt, fifo_wr}, {tbl[e].gnt, 1'b1});
            check("tbl_din", fifo_din, mk_din(w, req_data[w*DBITS +: DBITS]));
            tick;
            req = '0;
            tick;
        end

        // FIFO full blocks the grant without losing the request
        fifo_full = 1'b1;
        req       = 4'b0100;
        for (int c = 0; c < 20; c++) begin
            to_neg;
            check("full_hold", {gnt, fifo_wr}, 64'd0);
            tick;
        end
        fifo_full = 1'b0;
        to_neg;
        check("full_rel0", {gnt, fifo_wr}, 64'd0);
        tick;
        to_neg;
        check("full_rel1", {gnt, fifo_wr}, 64'd0);
        tick;
        to_neg;
        check("full_gnt", {gnt, fifo_wr}, {4'b0100, 1'b1});
        tick;
        req = '0;
        tick;

        // Read: strobe at +1, valid at +5, extra requests while busy (including the last busy cycle) ignored
        for (int c = 0; c < 12; c++) begin
            logic [2:0] ev;
            rd_req    = (c == 0) || (c == 2) || (c == 5);
            fifo_dout = OW'(8'h50 + c);
            ev = {1'(c == 1), 1'(c == 5), 1'(c >= 1 && c <= 5)};
            to_neg;
            check("rd_seq", {fifo_rd, rd_valid, rd_busy}, {61'd0, ev});
            if (c == 5) check("rd_data", rd_data, OW'(8'h53));
            tick;
        end
        rd_req = 1'b0;

        // Read request while empty is discarded
        fifo_empty = 1'b1;
        for (int c = 0; c < 10; c++) begin
            rd_req = (c == 0);
            to_neg;
            check("empty_rd", {fifo_rd, rd_valid, rd_busy}, 64'd0);
            tick;
        end
        fifo_empty = 1'b0;

        // Simultaneous write and read strobes
        req      = 4'b1000;
        req_data = {8'hA5, 24'h000000};
        to_neg;
        tick;
        rd_req = 1'b1;
        to_neg;
        tick;
        rd_req = 1'b0;
        to_neg;
        check("sim_strobes", {gnt, fifo_wr, fifo_rd}, {4'b1000, 1'b1, 1'b1});
        check("sim_din", fifo_din, mk_din(3, 8'hA5));
        tick;
        req = '0;
        repeat (8) tick;

        // Random traffic against a cycle-schedule model
        for (int n = 0; n < NARR; n++) begin
            exp_gnt[n]   = '0;
            exp_din[n]   = '0;
            exp_rd[n]    = 1'b0;
            exp_valid[n] = 1'b0;
            exp_busy[n]  = 1'b0;
            exp_src[n]   = 0;
            dout_hist[n] = '0;
        end
        for (int i = 0; i < NREQ; i++) rdat[i] = '0;
        reset = 1'b0;
        req   = '0;
        rq    = '0;
        tick;
        reset = 1'b1;
        wfree = 0;
        rfree = 0;
        ptr   = 0;
        for (int n = 0; n < NCYC + 12; n++) begin
            if (n < NCYC) begin
                for (int i = 0; i < NREQ; i++) begin
                    if (n >= 1 && exp_gnt[n-1][i]) begin
                        rq[i] = 1'b0;
                    end else if (!rq[i]) begin
                        if ($urandom_range(2, 0) == 0) begin
                            rq[i]   = 1'b1;
                            rdat[i] = DBITS'($urandom);
                        end
                    end else if ($urandom_range(19, 0) == 0) begin
                        rq[i] = 1'b0;
                    end
                end
                fifo_full  = ($urandom_range(3, 0) == 0);
                fifo_empty = ($urandom_range(3, 0) == 0);
                rd_req     = ($urandom_range(2, 0) == 0);
            end else begin
                rq         = '0;
                fifo_full  = 1'b0;
                fifo_empty = 1'b1;
                rd_req     = 1'b0;
            end
            fifo_dout    = OW'($urandom);
            dout_hist[n] = fifo_dout;
            req          = rq;
            for (int i = 0; i < NREQ; i++) req_data[i*DBITS +: DBITS] = rdat[i];

            if (n >= wfree && (|rq) && !fifo_full) begin
                w = -1;
                for (int k = 0; k < NREQ; k++) begin
                    if (w < 0 && rq[(ptr + k) % NREQ]) w = (ptr + k) % NREQ;
                end
                exp_gnt[n+2] = NREQ'(1) << w;
                exp_din[n+2] = mk_din(w, rdat[w]);
                ptr          = (w + 1) % NREQ;
                wfree        = n + 2 + GAP;
            end
            if (n >= rfree && rd_req && !fifo_empty) begin
                exp_rd[n+1] = 1'b1;
                for (int k = n + 1; k <= n + 3 + RD_LAT; k++) exp_busy[k] = 1'b1;
                exp_valid[n+3+RD_LAT] = 1'b1;
                exp_src[n+3+RD_LAT]   = n + 1 + RD_LAT;
                rfree = n + 4 + RD_LAT;
            end

            to_neg;
            check("rnd_ctl", {gnt, fifo_wr, fifo_rd, rd_valid, rd_busy},
                  {exp_gnt[n], |exp_gnt[n], exp_rd[n], exp_valid[n], exp_busy[n]});
            if (exp_gnt[n] != '0) check("rnd_din", fifo_din, exp_din[n]);
            if (exp_valid[n]) check("rnd_rdata", rd_data, dout_hist[exp_src[n]]);
            tick;
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
